ps2_host_ctrl: RTL

//  Owns the bidirectional PS/2 keyboard line. Sequences device->host receive

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_sync_edge.sv | 33 +++
 rtl/ps2_host_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host controller.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RX,
      ST_INHIBIT,
      ST_REQ,
      ST_TXB,
      ST_ACK,
      ST_WREL
   } ps2_state_e;

   localparam int PS2_FRAME_BITS = 11;

   localparam logic [7:0] SC_EXTEND   = 8'hE0;
   localparam logic [7:0] SC_BREAK    = 8'hF0;
   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] CMD_RESET   = 8'hFF;
   localparam logic [7:0] RSP_ACK     = 8'hFA;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronisers for the PS/2 clock and data pads, plus clock fall detect.
module ps2_sync_edge (
   input  logic gclk,
   input  logic grst_n,
   input  logic clk_pad,
   input  logic dat_pad,
   output logic clk_s,
   output logic dat_s,
   output logic fall
);

   logic [1:0] clk_ff;
   logic [1:0] dat_ff;
   logic       clk_prev;

   // Idle PS/2 lines float high, so the pipeline resets to 1 to avoid a false fall.
   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
         clk_ff   <= 2'b11;
         dat_ff   <= 2'b11;
         clk_prev <= 1'b1;
      end else begin
         clk_ff   <= {clk_ff[0], clk_pad};
         dat_ff   <= {dat_ff[0], dat_pad};
         clk_prev <= clk_ff[1];
      end
   end

   assign clk_s = clk_ff[1];
   assign dat_s = dat_ff[1];
   assign fall  = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host: receives device frames, sends command frames, and arbitrates the
// shared open-drain clock/data lines between the two directions.
module ps2_host_ctrl
   import ps2_pkg::*;
#(
   parameter int CLK_HZ     = 25_000_000,
   parameter int INHIBIT_US = 100,
   parameter int TIMEOUT_MS = 15
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   output logic       tx_done,
   output logic       tx_err,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       rx_err
);

   localparam int INH_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
   localparam int TO_CYC  = CLK_HZ / 1_000 * TIMEOUT_MS;
   localparam int MAX_CYC = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
   localparam int CW      = $clog2(MAX_CYC + 1);

   localparam logic [CW-1:0] TO_LAST   = CW'(TO_CYC - 1);
   localparam logic [CW-1:0] INH_LAST2 = CW'(INH_CYC - 2);
   localparam logic [3:0]    RX_LAST   = 4'(PS2_FRAME_BITS - 1);

   ps2_state_e state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    bitcnt, bitcnt_n;
   logic [9:0]    rx_sh, rx_sh_n, frame;
   logic [8:0]    tx_frame, tx_frame_n;
   logic          ack_ok, ack_ok_n;
   logic          clk_oe_n, dat_oe_n;
   logic          rx_valid_n, rx_err_n, tx_done_n, tx_err_n;
   logic [7:0]    rx_data_n;
   logic          ready_en, tx_abort;
   logic          clk_s, dat_s, fall, tmo;

   ps2_sync_edge u_sync (
      .gclk   (vga_clk),
      .grst_n (reset_n),
      .clk_pad(ps2_clk_i),
      .dat_pad(ps2_dat_i),
      .clk_s  (clk_s),
      .dat_s  (dat_s),
      .fall   (fall)
   );

   assign frame = {dat_s, rx_sh[9:1]};
   assign tmo   = (cnt == TO_LAST) && !fall;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         bitcnt     <= '0;
         rx_sh      <= '0;
         tx_frame   <= '0;
         ack_ok     <= 1'b0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
         rx_valid   <= 1'b0;
         rx_data    <= 8'h00;
         rx_err     <= 1'b0;
         tx_done    <= 1'b0;
         tx_err     <= 1'b0;
         ready_en   <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         bitcnt     <= bitcnt_n;
         rx_sh      <= rx_sh_n;
         tx_frame   <= tx_frame_n;
         ack_ok     <= ack_ok_n;
         ps2_clk_oe <= clk_oe_n;
         ps2_dat_oe <= dat_oe_n;
         rx_valid   <= rx_valid_n;
         rx_data    <= rx_data_n;
         rx_err     <= rx_err_n;
         tx_done    <= tx_done_n;
         tx_err     <= tx_err_n;
         ready_en   <= 1'b1;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      bitcnt_n   = bitcnt;
      rx_sh_n    = rx_sh;
      tx_frame_n = tx_frame;
      ack_ok_n   = ack_ok;
      clk_oe_n   = ps2_clk_oe;
      dat_oe_n   = ps2_dat_oe;
      rx_valid_n = 1'b0;
      rx_data_n  = rx_data;
      rx_err_n   = rx_err;
      tx_done_n  = 1'b0;
      tx_err_n   = tx_err;
      cmd_ready  = 1'b0;
      tx_abort   = 1'b0;

      case (state)
         ST_IDLE: begin
            cnt_n     = '0;
            clk_oe_n  = 1'b0;
            dat_oe_n  = 1'b0;
            cmd_ready = ready_en && !fall;
            if (fall) begin
               if (!dat_s) begin
                  state_n  = ST_RX;
                  bitcnt_n = 4'd1;
               end
            end else if (cmd_valid && cmd_ready) begin
               tx_frame_n = {odd_parity(cmd_data), cmd_data};
               clk_oe_n   = 1'b1;
               state_n    = ST_INHIBIT;
            end
         end

         ST_RX: begin
            if (fall) begin
               rx_sh_n  = frame;
               bitcnt_n = bitcnt + 4'd1;
               cnt_n    = '0;
               if (bitcnt == RX_LAST) begin
                  rx_valid_n = 1'b1;
                  rx_data_n  = frame[7:0];
                  rx_err_n   = (frame[8] != odd_parity(frame[7:0])) | ~frame[9];
                  state_n    = ST_IDLE;
               end
            end else if (tmo) begin
               rx_valid_n = 1'b1;
               rx_err_n   = 1'b1;
               state_n    = ST_IDLE;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         // Data is pulled one cycle before the clock is released, and that
         // overlap cycle is the last of the INH_CYC inhibit cycles.
         ST_INHIBIT: begin
            clk_oe_n = 1'b1;
            if (cnt == INH_LAST2) begin
               dat_oe_n = 1'b1;
               cnt_n    = '0;
               state_n  = ST_REQ;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         ST_REQ: begin
            clk_oe_n = 1'b0;
            dat_oe_n = 1'b1;
            bitcnt_n = '0;
            cnt_n    = '0;
            state_n  = ST_TXB;
         end

         ST_TXB: begin
            if (fall) begin
               cnt_n    = '0;
               bitcnt_n = bitcnt + 4'd1;
               if (bitcnt <= 4'd8) begin
                  dat_oe_n = ~tx_frame[bitcnt];
               end else begin
                  dat_oe_n = 1'b0;
                  state_n  = ST_ACK;
               end
            end else if (tmo) begin
               tx_abort = 1'b1;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         ST_ACK: begin
            if (fall) begin
               ack_ok_n = ~dat_s;
               cnt_n    = '0;
               state_n  = ST_WREL;
            end else if (tmo) begin
               tx_abort = 1'b1;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         ST_WREL: begin
            if (clk_s && dat_s) begin
               tx_done_n = 1'b1;
               tx_err_n  = ~ack_ok;
               state_n   = ST_IDLE;
            end else if (fall) begin
               cnt_n = '0;
            end else if (tmo) begin
               tx_abort = 1'b1;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end

         default: state_n = ST_IDLE;
      endcase

      if (tx_abort) begin
         clk_oe_n  = 1'b0;
         dat_oe_n  = 1'b0;
         tx_done_n = 1'b1;
         tx_err_n  = 1'b1;
         state_n   = ST_IDLE;
      end
   end

endmodule
